bcd_converter: RTL



---
 rtl/bcd_pkg.sv | 14 +
 rtl/bcd_digit_adj.sv | 17 +
 rtl/bcd_converter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states and digit constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD3  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int unsigned      c_Digit_Bits     = 4;
  localparam logic [3:0]       c_Blank_Code     = 4'hF;
  localparam logic [3:0]       c_Add3_Threshold = 4'd5;

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Add-3 correction for one BCD digit ahead of the next shift.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [c_Digit_Bits-1:0] digit_i,
  output logic [c_Digit_Bits-1:0] digit_o
);

  // Digits of 5..9 get +3 so the following shift carries correctly into the next digit.
  always_comb begin
    digit_o = digit_i;
    if (digit_i >= c_Add3_Threshold) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule : bcd_digit_adj

// File: rtl/bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter with valid/ready input
// and a one-cycle result pulse. Optional leading-digit blanking is enabled by
// defining BCD_LEADING_BLANK_EN.
module bcd_converter
  import bcd_pkg::*;
#(
  parameter int unsigned g_Width  = 12,
  parameter int unsigned g_Digits = 4
) (
  input  logic                                i_Clk,
  input  logic                                i_Reset,
  input  logic                                i_Valid,
  input  logic [g_Width-1:0]                  i_Binary,
  output logic                                o_Ready,
  output logic [c_Digit_Bits*g_Digits-1:0]    o_BCD,
  output logic                                o_Valid,
  output logic                                o_Overflow
);

  localparam int unsigned BcdW = c_Digit_Bits * g_Digits;
  localparam int unsigned CntW = (g_Width > 1) ? $clog2(g_Width) : 1;

  state_e            state_q;
  logic [g_Width-1:0] shift_q;
  logic [BcdW-1:0]   digits_q;
  logic [CntW-1:0]   cnt_q;
  logic              acc_ovf_q;
  logic              ready_q;
  logic              valid_q;
  logic [BcdW-1:0]   bcd_q;
  logic              ovf_q;

  logic [BcdW-1:0]    digits_adj_d;
  logic [BcdW-1:0]    digits_shl_d;
  logic [g_Width-1:0] shift_shl_d;
  logic               ovf_bit_d;
  logic [BcdW-1:0]    commit_bcd_d;

  // One add-3 corrector per digit.
  for (genvar g = 0; g < g_Digits; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (digits_q[g*c_Digit_Bits +: c_Digit_Bits]),
      .digit_o (digits_adj_d[g*c_Digit_Bits +: c_Digit_Bits])
    );
  end

  // Left shift of the {digits, binary} pair; the bit leaving the top digit feeds overflow.
  always_comb begin
    digits_shl_d = BcdW'({digits_q, shift_q[g_Width-1]});
    shift_shl_d  = g_Width'({shift_q, 1'b0});
    ovf_bit_d    = digits_q[BcdW-1];
  end

`ifdef BCD_LEADING_BLANK_EN
  logic nz_seen;

  // Replace digits above the most significant non-zero digit with the blank code; digit 0 always shows.
  always_comb begin
    commit_bcd_d = digits_shl_d;
    nz_seen      = 1'b0;
    for (int i = int'(g_Digits) - 1; i > 0; i--) begin
      if (digits_shl_d[i*c_Digit_Bits +: c_Digit_Bits] != '0) begin
        nz_seen = 1'b1;
      end
      if (!nz_seen) begin
        commit_bcd_d[i*c_Digit_Bits +: c_Digit_Bits] = c_Blank_Code;
      end
    end
  end
`else
  // Plain BCD with leading zeros.
  assign commit_bcd_d = digits_shl_d;
`endif

  // Conversion FSM with datapath registers and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      digits_q  <= '0;
      cnt_q     <= '0;
      acc_ovf_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_Valid && ready_q) begin
            shift_q   <= i_Binary;
            digits_q  <= '0;
            acc_ovf_q <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            state_q   <= ST_ADD3;
          end
        end
        ST_ADD3: begin
          digits_q <= digits_adj_d;
          state_q  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          digits_q  <= digits_shl_d;
          shift_q   <= shift_shl_d;
          acc_ovf_q <= acc_ovf_q | ovf_bit_d;
          cnt_q     <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(g_Width - 1)) begin
            bcd_q   <= commit_bcd_d;
            ovf_q   <= acc_ovf_q | ovf_bit_d;
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_ADD3;
          end
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_Ready    = ready_q;
  assign o_Valid    = valid_q;
  assign o_BCD      = bcd_q;
  assign o_Overflow = ovf_q;

endmodule : bcd_converter
